sub24_seq: RTL and testbench



---
 rtl/sub24_seq_if.sv | 26 ++
 rtl/sub24_seq.sv | 113 +++++++++++
 tb/tb_sub24_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sub24_seq_if.sv
// Operand and result handshake bundle for the segmented 24-bit subtractor.
// master drives operands and accepts results; slave is the subtractor.
interface sub24_seq_if #(
    parameter int W = 24
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         b0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] D;
    logic         b24;
    logic         sx;

    modport master (
        output in_valid, A, B, b0, out_ready,
        input  in_ready, out_valid, D, b24, sx
    );

    modport slave (
        input  in_valid, A, B, b0, out_ready,
        output in_ready, out_valid, D, b24, sx
    );
endinterface

// File: rtl/sub24_seq.sv
// Multi-cycle 24-bit subtractor: one SEG_W-bit segment per clock,
// borrow rippled through a register, sx flags inter-segment borrows.
module sub24_seq #(
    parameter int SEG_W = 8,
    parameter int NSEG  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    sub24_seq_if.slave  bus
);
    localparam int W  = SEG_W * NSEG;
    localparam int CW = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            borrow_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    res_q;
    logic [W-1:0]    res_d;
    logic            b24_q;
    logic            sx_q;
    logic            in_ready_q;
    logic            out_valid_q;

    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic [SEG_W:0]   diff;
    logic             last;

    // Select the active segment, subtract it, and splice it into the result.
    always_comb begin
        seg_a = '0;
        seg_b = '0;
        for (int i = 0; i < NSEG; i++) begin
            if (cnt_q == CW'(i)) begin
                seg_a = a_q[i*SEG_W +: SEG_W];
                seg_b = b_q[i*SEG_W +: SEG_W];
            end
        end
        diff  = {1'b0, seg_a} - {1'b0, seg_b}
              - {{SEG_W{1'b0}}, borrow_q};
        res_d = res_q;
        for (int i = 0; i < NSEG; i++) begin
            if (cnt_q == CW'(i)) begin
                res_d[i*SEG_W +: SEG_W] = diff[SEG_W-1:0];
            end
        end
        last = (cnt_q == CW'(NSEG - 1));
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            b24_q       <= 1'b0;
            sx_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.A;
                        b_q        <= bus.B;
                        borrow_q   <= bus.b0;
                        res_q      <= '0;
                        sx_q       <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    res_q    <= res_d;
                    borrow_q <= diff[SEG_W];
                    cnt_q    <= cnt_q + CW'(1);
                    if (!last && diff[SEG_W]) begin
                        sx_q <= 1'b1;
                    end
                    if (last) begin
                        b24_q       <= diff[SEG_W];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = res_q;
    assign bus.b24       = b24_q;
    assign bus.sx        = sx_q;
endmodule

// File: tb/tb_sub24_seq.sv
// Directed self-checking bench for sub24_seq.
// Each task drives one scenario and compares inline.
module tb_sub24_seq;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    sub24_seq_if #(.W(24)) bus ();

    sub24_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_vector(input logic [23:0] a, input logic [23:0] b,
                               input logic bi, input logic [23:0] ed,
                               input logic eb, input logic es,
                               input string nm);
        int n;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.A         = a;
        bus.B         = b;
        bus.b0        = bi;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_total++;
        if (bus.in_ready !== 1'b0)
            $display("FAIL %s_accept in_ready=%b want 0", nm, bus.in_ready);
        else n_pass++;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        n_total++;
        if (n != 3)
            $display("FAIL %s_latency got %0d edges want 3", nm, n);
        else n_pass++;
        n_total++;
        if ({bus.D, bus.b24, bus.sx} !== {ed, eb, es})
            $display("FAIL %s_result D=%h b24=%b sx=%b want D=%h b24=%b sx=%b",
                     nm, bus.D, bus.b24, bus.sx, ed, eb, es);
        else n_pass++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01)
            $display("FAIL %s_handshake out_valid=%b in_ready=%b want 0 1",
                     nm, bus.out_valid, bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_total++;
        if ({bus.in_ready, bus.out_valid, bus.D, bus.b24, bus.sx} !==
            {1'b1, 1'b0, 24'h0, 1'b0, 1'b0})
            $display("FAIL reset_in rdy=%b vld=%b D=%h b24=%b sx=%b want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.D, bus.b24, bus.sx);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({bus.in_ready, bus.out_valid, bus.D} !== {1'b1, 1'b0, 24'h0})
            $display("FAIL reset_after rdy=%b vld=%b D=%h want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.D);
        else n_pass++;
    endtask

    task automatic test_basic();
        test_vector(24'h000010, 24'h000001, 1'b0, 24'h00000F, 1'b0, 1'b0, "simple");
        test_vector(24'h000100, 24'h000001, 1'b0, 24'h0000FF, 1'b0, 1'b1, "seg_borrow");
        test_vector(24'h000000, 24'h000000, 1'b1, 24'hFFFFFF, 1'b1, 1'b1, "underflow");
        test_vector(24'h123456, 24'h123456, 1'b0, 24'h000000, 1'b0, 1'b0, "equal");
        test_vector(24'h010000, 24'h000000, 1'b1, 24'h00FFFF, 1'b0, 1'b1, "ripple2");
        test_vector(24'h000000, 24'h010000, 1'b0, 24'hFF0000, 1'b1, 1'b0, "top_only");
    endtask

    task automatic test_backpressure();
        int n;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.A         = 24'h000100;
        bus.B         = 24'h000001;
        bus.b0        = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        n_total++;
        if (n != 3)
            $display("FAIL bp_latency got %0d edges want 3", n);
        else n_pass++;
        bus.in_valid = 1'b1;
        bus.A        = 24'hFFFFFF;
        bus.B        = 24'h000000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_total++;
            if ({bus.out_valid, bus.in_ready, bus.D, bus.b24, bus.sx} !==
                {1'b1, 1'b0, 24'h0000FF, 1'b0, 1'b1})
                $display("FAIL bp_hold%0d vld=%b rdy=%b D=%h b24=%b sx=%b want 1 0 0000ff 0 1",
                         i, bus.out_valid, bus.in_ready, bus.D, bus.b24, bus.sx);
            else n_pass++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_total++;
        if ({bus.out_valid, bus.in_ready, bus.D, bus.sx} !==
            {1'b0, 1'b1, 24'h0000FF, 1'b1})
            $display("FAIL bp_release vld=%b rdy=%b D=%h sx=%b want 0 1 0000ff 1",
                     bus.out_valid, bus.in_ready, bus.D, bus.sx);
        else n_pass++;
    endtask

    task automatic test_input_change();
        int n;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.A        = 24'h000100;
        bus.B        = 24'h000001;
        bus.b0       = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.A        = 24'hABCDEF;
        bus.B        = 24'h111111;
        bus.b0       = 1'b1;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        n_total++;
        if ({bus.D, bus.b24, bus.sx} !== {24'h0000FF, 1'b0, 1'b1})
            $display("FAIL in_change D=%h b24=%b sx=%b want 0000ff 0 1",
                     bus.D, bus.b24, bus.sx);
        else n_pass++;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.A        = 24'h000000;
        bus.B        = 24'h000000;
        bus.b0       = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.in_ready, bus.out_valid, bus.D, bus.b24, bus.sx} !==
            {1'b1, 1'b0, 24'h0, 1'b0, 1'b0})
            $display("FAIL mid_reset rdy=%b vld=%b D=%h b24=%b sx=%b want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.D, bus.b24, bus.sx);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        test_vector(24'h800000, 24'h000001, 1'b0, 24'h7FFFFF, 1'b0, 1'b1, "post_reset");
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.b0        = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        test_reset();
        test_basic();
        test_backpressure();
        test_input_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
